mem_arbiter: RTL and testbench

Single-port RAM arbiter between the CPU memory strobes and an external loader/debug port. It sits between the CPU (`addr_bus`, `c_ri`, `c_ro`, data) and the RAM, and serves exactly one requester per clock. The CPU always has priority. The loader is served in free cycles. Starvation, or an explicit hold from the loader, freezes the CPU through `cpu_stall` so program loading and inspection can proceed.

---
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: the CPU has same-cycle priority, and the loader is served in free cycles.
// Loader starvation or an explicit loader hold freezes the CPU through cpu_stall.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  cpu_ri,
    input  logic                  cpu_ro,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  ld_req,
    input  logic                  ld_we,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_wdata,
    input  logic                  ld_hold,
    output logic                  ld_ack,
    output logic [DATA_WIDTH-1:0] ld_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_we,
    output logic                  ram_re,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic {
        IDLE,
        ACK
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       starve_cnt_q, starve_cnt_d;
    logic                   starve_stall_q, starve_stall_d;
    logic                   hold_stall_q, hold_stall_d;
    logic                   ld_ack_q, ld_ack_d;
    logic [DATA_WIDTH-1:0]  ld_rdata_q, ld_rdata_d;
    logic                   cpu_req;
    logic                   ld_grant;

    assign cpu_stall = starve_stall_q | hold_stall_q;
    assign ld_ack    = ld_ack_q;
    assign ld_rdata  = ld_rdata_q;

    // A frozen CPU holds its strobes static, so they are masked while stalled; reset masks everything.
    always_comb begin
        cpu_req   = (cpu_ri | cpu_ro) & ~cpu_stall & ~reset;
        ld_grant  = (state_q == IDLE) & ld_req & ~cpu_req & ~reset;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        cpu_rdata = '0;
        if (cpu_req) begin
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
            ram_we    = cpu_ri;
            ram_re    = cpu_ro & ~cpu_ri;
            cpu_rdata = ram_rdata;
        end else if (ld_grant) begin
            ram_addr  = ld_addr;
            ram_wdata = ld_wdata;
            ram_we    = ld_we;
            ram_re    = ~ld_we;
        end
    end

    always_comb begin
        state_d        = ld_grant ? ACK : IDLE;
        ld_ack_d       = ld_grant;
        ld_rdata_d     = (ld_grant && !ld_we) ? ram_rdata : ld_rdata_q;
        hold_stall_d   = ld_hold;
        starve_cnt_d   = starve_cnt_q;
        starve_stall_d = starve_stall_q;
        if (!ld_req || ld_grant) begin
            starve_cnt_d = '0;
        end else if (state_q == IDLE && cpu_req) begin
            if (starve_cnt_q != LIMIT) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
            if (starve_cnt_q + 1'b1 == LIMIT) begin
                starve_stall_d = 1'b1;
            end
        end
        // The starvation stall only needs to last until the loader gets its one transfer.
        if (ld_grant) begin
            starve_stall_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            starve_cnt_q   <= '0;
            starve_stall_q <= 1'b0;
            hold_stall_q   <= 1'b0;
            ld_ack_q       <= 1'b0;
            ld_rdata_q     <= '0;
        end else begin
            state_q        <= state_d;
            starve_cnt_q   <= starve_cnt_d;
            starve_stall_q <= starve_stall_d;
            hold_stall_q   <= hold_stall_d;
            ld_ack_q       <= ld_ack_d;
            ld_rdata_q     <= ld_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural RAM model.
// Inputs change 1 time unit after each rising edge; outputs are sampled on the falling edge.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic       cpu_ri, cpu_ro, cpu_stall;
    logic       ld_req, ld_we, ld_hold, ld_ack;
    logic [7:0] ld_addr, ld_wdata, ld_rdata;
    logic [7:0] ram_addr, ram_wdata, ram_rdata;
    logic       ram_we, ram_re;

    logic [7:0] mem [0:255];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign ram_rdata = mem[ram_addr];

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_ri(cpu_ri), .cpu_ro(cpu_ro),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_hold(ld_hold), .ld_ack(ld_ack), .ld_rdata(ld_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
        .ram_rdata(ram_rdata)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic ri, input logic ro, input logic [7:0] ca,
                                 input logic [7:0] cd);
        cpu_ri    = ri;
        cpu_ro    = ro;
        cpu_addr  = ca;
        cpu_wdata = cd;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = 8'h00; ld_wdata = 8'h00; ld_hold = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        sample();
        checkOutput("reset_stall", 32'(cpu_stall), 32'd0);
        checkOutput("reset_ack", 32'(ld_ack), 32'd0);
        checkOutput("idle_ram_addr", 32'(ram_addr), 32'h00);
        checkOutput("idle_cpu_rdata", 32'(cpu_rdata), 32'h00);
        tick();

        // Reset asserted in the grant cycle of a loader write.
        reset = 1'b1;
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h10; ld_wdata = 8'h99;
        sample();
        checkOutput("rst_mid_ram_we", 32'(ram_we), 32'd0);
        tick();
        reset = 1'b0;
        ld_req = 1'b0;
        sample();
        checkOutput("rst_mid_ack", 32'(ld_ack), 32'd0);
        checkOutput("rst_mid_stall", 32'(cpu_stall), 32'd0);
        checkOutput("rst_mid_rdata", 32'(ld_rdata), 32'h00);
        checkOutput("rst_mid_state", 32'(dut.state_q), 32'd0);
        tick();

        // Preload RAM through CPU writes.
        applyStimulus(1'b1, 1'b0, 8'h05, 8'hAB);
        tick();
        applyStimulus(1'b1, 1'b0, 8'h20, 8'hC3);
        tick();
        applyStimulus(1'b1, 1'b0, 8'h30, 8'h5A);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        sample();
        checkOutput("preload_05", 32'(mem[8'h05]), 32'hAB);
        checkOutput("preload_30", 32'(mem[8'h30]), 32'h5A);
        tick();

        // CPU priority over a simultaneous loader read.
        applyStimulus(1'b0, 1'b1, 8'h05, 8'h00);
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 8'h20;
        sample();
        checkOutput("prio_cpu_rdata", 32'(cpu_rdata), 32'hAB);
        checkOutput("prio_ram_addr", 32'(ram_addr), 32'h05);
        checkOutput("prio_ram_re", 32'(ram_re), 32'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        sample();
        checkOutput("prio_ld_grant_addr", 32'(ram_addr), 32'h20);
        checkOutput("prio_ld_grant_re", 32'(ram_re), 32'd1);
        checkOutput("prio_no_ack_yet", 32'(ld_ack), 32'd0);
        tick();
        ld_req = 1'b0;
        sample();
        checkOutput("prio_ack", 32'(ld_ack), 32'd1);
        checkOutput("prio_ld_rdata", 32'(ld_rdata), 32'hC3);
        tick();
        sample();
        checkOutput("prio_ack_pulse", 32'(ld_ack), 32'd0);
        tick();

        // Starvation: CPU writes 0x50 every cycle, loader reads 0x30 from cycle 0.
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 8'h30;
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, 1'b0, 8'h50, 8'hEE);
            sample();
            checkOutput($sformatf("starve_c%0d_stall", c), 32'(cpu_stall), 32'd0);
            checkOutput($sformatf("starve_c%0d_we", c), 32'(ram_we), 32'd1);
            tick();
        end
        applyStimulus(1'b1, 1'b0, 8'h50, 8'hFF);
        sample();
        checkOutput("starve_c4_stall", 32'(cpu_stall), 32'd1);
        checkOutput("starve_c4_we", 32'(ram_we), 32'd0);
        checkOutput("starve_c4_addr", 32'(ram_addr), 32'h30);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        ld_req = 1'b0;
        sample();
        checkOutput("starve_c5_ack", 32'(ld_ack), 32'd1);
        checkOutput("starve_c5_rdata", 32'(ld_rdata), 32'h5A);
        checkOutput("starve_c5_stall", 32'(cpu_stall), 32'd0);
        checkOutput("starve_no_cpu_write", 32'(mem[8'h50]), 32'hEE);
        tick();

        // Hold and load with the CPU read strobe stuck high.
        applyStimulus(1'b0, 1'b1, 8'h05, 8'h00);
        ld_hold = 1'b1;
        sample();
        checkOutput("hold_rise_stall", 32'(cpu_stall), 32'd0);
        checkOutput("hold_rise_cpu_rdata", 32'(cpu_rdata), 32'hAB);
        tick();
        sample();
        checkOutput("hold_stall", 32'(cpu_stall), 32'd1);
        checkOutput("hold_no_cpu_grant", 32'(cpu_rdata), 32'h00);
        tick();
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h00; ld_wdata = 8'h11;
        for (int i = 0; i < 3; i++) begin
            sample();
            checkOutput($sformatf("load%0d_we", i), 32'(ram_we), 32'd1);
            checkOutput($sformatf("load%0d_addr", i), 32'(ram_addr), 32'(i));
            checkOutput($sformatf("load%0d_cpu_rdata", i), 32'(cpu_rdata), 32'h00);
            tick();
            if (i < 2) begin
                ld_addr  = 8'(i + 1);
                ld_wdata = (i == 0) ? 8'h22 : 8'h33;
            end else begin
                ld_req = 1'b0;
            end
            sample();
            checkOutput($sformatf("load%0d_ack", i), 32'(ld_ack), 32'd1);
            checkOutput($sformatf("load%0d_ack_we", i), 32'(ram_we), 32'd0);
            tick();
        end
        sample();
        checkOutput("load_mem0", 32'(mem[8'h00]), 32'h11);
        checkOutput("load_mem1", 32'(mem[8'h01]), 32'h22);
        checkOutput("load_mem2", 32'(mem[8'h02]), 32'h33);
        checkOutput("load_rdata_kept", 32'(ld_rdata), 32'h5A);
        checkOutput("load_ack_gone", 32'(ld_ack), 32'd0);
        tick();
        ld_hold = 1'b0;
        sample();
        checkOutput("hold_fall_stall", 32'(cpu_stall), 32'd1);
        tick();
        sample();
        checkOutput("hold_release_stall", 32'(cpu_stall), 32'd0);
        checkOutput("hold_release_rdata", 32'(cpu_rdata), 32'hAB);
        tick();

        // Simultaneous strobes: write wins.
        applyStimulus(1'b1, 1'b1, 8'h40, 8'h77);
        sample();
        checkOutput("both_we", 32'(ram_we), 32'd1);
        checkOutput("both_re", 32'(ram_re), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        sample();
        checkOutput("both_mem40", 32'(mem[8'h40]), 32'h77);
        tick();

        // Withdrawn request after two denied cycles.
        applyStimulus(1'b0, 1'b1, 8'h05, 8'h00);
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 8'h20;
        tick();
        tick();
        sample();
        checkOutput("withdraw_cnt2", 32'(dut.starve_cnt_q), 32'd2);
        ld_req = 1'b0;
        tick();
        sample();
        checkOutput("withdraw_cnt0", 32'(dut.starve_cnt_q), 32'd0);
        checkOutput("withdraw_no_ack", 32'(ld_ack), 32'd0);
        checkOutput("withdraw_stall", 32'(cpu_stall), 32'd0);
        tick();
        sample();
        checkOutput("withdraw_no_ack_late", 32'(ld_ack), 32'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
